// File: rtl/sram_1rw_req_ctrl_pkg.sv
// Purpose: shared widths, lane size, command encoding and counter helper for the SRAM request controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package sram_1rw_req_ctrl_pkg;

    localparam int LANE_WIDTH     = 22;
    localparam int NUM_WMASKS_DEF = 4;
    localparam int DATA_WIDTH_DEF = NUM_WMASKS_DEF * LANE_WIDTH;
    localparam int ADDR_WIDTH_DEF = 6;
    localparam int RSP_DEPTH_DEF  = 4;
    localparam int STAT_W         = 16;

    // What an accepted request turns into on the SRAM port.
    typedef enum logic [1:0] {
        CMD_IDLE  = 2'd0,
        CMD_READ  = 2'd1,
        CMD_WRITE = 2'd2
    } sram_cmd_e;

    typedef logic [STAT_W-1:0] stat_cnt_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic stat_cnt_t sat_inc(input stat_cnt_t v);
        return (v == '1) ? v : v + stat_cnt_t'(1);
    endfunction

endpackage

// File: rtl/sram_rsp_fifo.sv
// Purpose: synchronous response FIFO holding captured SRAM read data until the consumer takes it.
// Latency: a push is visible at the output the cycle after the push edge; pop and push may share an edge.
// Backpressure: push ignored when full, pop ignored when empty; pop_dat holds until popped.
module sram_rsp_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 88,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_rdy,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             do_push;
    logic             do_pop;

    assign full    = (cnt_q == CNT_W'(DEPTH));
    assign empty   = (cnt_q == '0);
    assign count   = cnt_q;
    assign do_push = push_vld && !full;
    assign do_pop  = pop_rdy && !empty;
    assign pop_dat = empty ? '0 : mem_q[rd_ptr_q];

    // Pointer wrap is explicit so non-power-of-two depths work.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + CNT_W'(1);
            2'b01:   cnt_d = cnt_q - CNT_W'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Control state; storage contents need no reset because the count gates visibility.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Data storage written at the tail slot.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/sram_1rw_req_ctrl.sv
// Purpose: valid/ready front end for a single-port 1RW SRAM with in-order read responses; SRAM_CTRL_STATS_EN adds rd_cnt/wr_cnt.
// Latency: SRAM pins registered on acceptance, read data captured two edges later, rsp_valid two cycles after acceptance.
// Backpressure: credit-based; req_ready only while FIFO occupancy plus reads in flight is below RSP_DEPTH.
module sram_1rw_req_ctrl
    import sram_1rw_req_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
    parameter int NUM_WMASKS = NUM_WMASKS_DEF,
    parameter int RSP_DEPTH  = RSP_DEPTH_DEF
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_WMASKS-1:0] req_wmask,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  csb0,
    output logic                  web0,
    output logic [NUM_WMASKS-1:0] wmask0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
`ifdef SRAM_CTRL_STATS_EN
    output logic [15:0]           rd_cnt,
    output logic [15:0]           wr_cnt,
`endif
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int FCNT_W = $clog2(RSP_DEPTH + 1);
    localparam int CRED_W = $clog2(RSP_DEPTH + 3);

    sram_cmd_e             cmd;
    logic                  accept;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [NUM_WMASKS-1:0] wmask_q, wmask_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic                  s1_rd_q, s1_rd_d;   // read currently on the SRAM pins
    logic                  s2_rd_q, s2_rd_d;   // read sampled by the SRAM, dout0 captured next edge
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_rdata;
    logic [FCNT_W-1:0]     fifo_cnt;
    logic [CRED_W-1:0]     credit;

    // Every in-flight read already owns a FIFO slot, so a capture can never find the FIFO full.
    assign credit    = CRED_W'(fifo_cnt) + CRED_W'(s1_rd_q) + CRED_W'(s2_rd_q);
    assign req_ready = !rst0 && (credit < CRED_W'(RSP_DEPTH));
    assign accept    = req_valid && req_ready;

    assign csb0   = csb_q;
    assign web0   = web_q;
    assign wmask0 = wmask_q;
    assign addr0  = addr_q;
    assign din0   = din_q;

    assign fifo_push = s2_rd_q && !fifo_full;
    assign fifo_pop  = rsp_valid && rsp_ready;
    assign rsp_valid = !rst0 && !fifo_empty;
    assign rsp_rdata = rsp_valid ? fifo_rdata : '0;

    // Classify the accepted request; an all-zero-mask write is accepted but touches nothing.
    always_comb begin
        cmd = CMD_IDLE;
        if (accept) begin
            if (!req_we) begin
                cmd = CMD_READ;
            end else if (req_wmask != '0) begin
                cmd = CMD_WRITE;
            end
        end
    end

    // Next state for SRAM pins and the two-stage read tracker.
    always_comb begin
        csb_d   = (cmd == CMD_IDLE);
        web_d   = (cmd != CMD_WRITE);
        wmask_d = wmask_q;
        addr_d  = addr_q;
        din_d   = din_q;
        if (accept) begin
            wmask_d = req_wmask;
            addr_d  = req_addr;
            din_d   = req_wdata;
        end
        s1_rd_d = (cmd == CMD_READ);
        s2_rd_d = s1_rd_q;
    end

    // Register the SRAM pins and in-flight flags; reset drops any read already sent.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            csb_q   <= 1'b1;
            web_q   <= 1'b1;
            wmask_q <= '0;
            addr_q  <= '0;
            din_q   <= '0;
            s1_rd_q <= 1'b0;
            s2_rd_q <= 1'b0;
        end else begin
            csb_q   <= csb_d;
            web_q   <= web_d;
            wmask_q <= wmask_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
            s1_rd_q <= s1_rd_d;
            s2_rd_q <= s2_rd_d;
        end
    end

    sram_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .clk      (clk0),
        .rst      (rst0),
        .push_vld (fifo_push),
        .push_dat (dout0),
        .pop_rdy  (fifo_pop),
        .pop_dat  (fifo_rdata),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_cnt)
    );

`ifdef SRAM_CTRL_STATS_EN
    stat_cnt_t rd_cnt_q, rd_cnt_d;
    stat_cnt_t wr_cnt_q, wr_cnt_d;

    // Count issued SRAM operations, saturating.
    always_comb begin
        rd_cnt_d = (cmd == CMD_READ)  ? sat_inc(rd_cnt_q) : rd_cnt_q;
        wr_cnt_d = (cmd == CMD_WRITE) ? sat_inc(wr_cnt_q) : wr_cnt_q;
    end

    // Statistics registers cleared with the rest of the block.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            rd_cnt_q <= rd_cnt_d;
            wr_cnt_q <= wr_cnt_d;
        end
    end

    assign rd_cnt = rd_cnt_q;
    assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_1rw_req_ctrl.sv
// Purpose: self-checking bench for sram_1rw_req_ctrl with a behavioural 1RW SRAM and a response scoreboard.
// Latency: model SRAM samples at posedge, writes/reads out at the following negedge.
// Backpressure: rsp_ready driven by the stimulus process; monitor pops expectations on every handshake.
module tb_sram_1rw_req_ctrl;

    localparam int DW = 88;
    localparam int AW = 6;
    localparam int NW = 4;
    localparam int LW = 22;

    logic          clk0 = 1'b0;
    logic          rst0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [AW-1:0] req_addr;
    logic [NW-1:0] req_wmask;
    logic [DW-1:0] req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;
    logic          csb0;
    logic          web0;
    logic [NW-1:0] wmask0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] din0;
    logic [DW-1:0] dout0;
`ifdef SRAM_CTRL_STATS_EN
    logic [15:0]   rd_cnt;
    logic [15:0]   wr_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;
    logic [DW-1:0] exp_q [$];

    always #5 clk0 = ~clk0;

    sram_1rw_req_ctrl dut (
        .clk0      (clk0),
        .rst0      (rst0),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wmask (req_wmask),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .csb0      (csb0),
        .web0      (web0),
        .wmask0    (wmask0),
        .addr0     (addr0),
        .din0      (din0),
`ifdef SRAM_CTRL_STATS_EN
        .rd_cnt    (rd_cnt),
        .wr_cnt    (wr_cnt),
`endif
        .dout0     (dout0)
    );

    // Behavioural single-port SRAM: inputs latched at posedge, array/dout updated at negedge.
    logic [DW-1:0] sram_mem [64];
    logic          s_csb;
    logic          s_web;
    logic [AW-1:0] s_addr;
    logic [NW-1:0] s_mask;
    logic [DW-1:0] s_din;

    always @(posedge clk0) begin
        s_csb  <= csb0;
        s_web  <= web0;
        s_addr <= addr0;
        s_mask <= wmask0;
        s_din  <= din0;
    end

    always @(negedge clk0) begin
        if (s_csb === 1'b0) begin
            if (s_web === 1'b0) begin
                for (int l = 0; l < NW; l++) begin
                    if (s_mask[l]) sram_mem[s_addr][l*LW +: LW] <= s_din[l*LW +: LW];
                end
            end else begin
                dout0 <= sram_mem[s_addr];
            end
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [DW-1:0] pat(input int a);
        logic [7:0] b;
        b = 8'(a * 37 + 11);
        return {11{b}};
    endfunction

    // Monitor: pops one expectation per response handshake and checks hold-stability under stall.
    logic          prev_hold = 1'b0;
    logic [DW-1:0] prev_dat  = '0;

    always @(negedge clk0) begin
        if (rst0) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) check("rsp_hold_stable", {rsp_valid, rsp_rdata}, {1'b1, prev_dat});
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) check("unexpected_rsp", rsp_valid, 1'b0);
                else check("rsp_rdata", rsp_rdata, exp_q.pop_front());
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_dat  = rsp_rdata;
        end
    end

    // Present one request, wait (bounded) for acceptance, and optionally queue the expected read data.
    task automatic do_req(input logic we, input logic [AW-1:0] addr, input logic [NW-1:0] mask,
                          input logic [DW-1:0] data, input logic push_exp, input logic [DW-1:0] exp);
        logic ok = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wmask = mask;
        req_wdata = data;
        for (int c = 0; c < 50; c++) begin
            if (req_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk0); #1;
        end
        if (ok) begin
            if (push_exp) exp_q.push_back(exp);
            @(posedge clk0); #1;
        end else begin
            check("req_accept_timeout", req_ready, 1'b1);
        end
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 300; c++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk0);
        end
        repeat (3) @(negedge clk0);
        check("drain_queue_empty", exp_q.size(), 0);
        check("drain_rsp_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  acc;
        logic seen;
        rst0      = 1'b1;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wmask = '0;
        req_wdata = '0;
        rsp_ready = 1'b1;

        // Reset values.
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        check("rst_csb0", csb0, 1'b1);
        check("rst_web0", web0, 1'b1);
        check("rst_wmask0", wmask0, 4'h0);
        check("rst_addr0", addr0, 6'h0);
        check("rst_din0", din0, 88'h0);
        check("rst_req_ready", req_ready, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_rdata", rsp_rdata, 88'h0);
        @(posedge clk0); #1;
        rst0 = 1'b0;
        @(negedge clk0);
        check("ready_after_rst", req_ready, 1'b1);

        // Full write then back-to-back read of the same word, with latency checks.
        do_req(1'b1, 6'd5, 4'b1111, {11{8'hA5}}, 1'b0, '0);
        do_req(1'b0, 6'd5, 4'b0000, '0, 1'b1, {11{8'hA5}});
        check("lat_at_accept", rsp_valid, 1'b0);
        @(posedge clk0); #1;
        check("lat_1cyc", rsp_valid, 1'b0);
        @(posedge clk0); #1;
        check("lat_2cyc", rsp_valid, 1'b1);
        wait_idle();

        // Partial-lane write over a zero word.
        do_req(1'b1, 6'd5, 4'b1111, 88'h0, 1'b0, '0);
        do_req(1'b1, 6'd5, 4'b0010, {DW{1'b1}}, 1'b0, '0);
        check("wr_csb0", csb0, 1'b0);
        check("wr_web0", web0, 1'b0);
        check("wr_wmask0", wmask0, 4'b0010);
        check("wr_addr0", addr0, 6'd5);
        check("wr_din0", din0, {DW{1'b1}});
        do_req(1'b0, 6'd5, 4'b0000, '0, 1'b1, 88'hFFFFFC00000);
        wait_idle();

        // Zero-mask write is accepted but must not touch the SRAM.
        do_req(1'b1, 6'd5, 4'b0000, 88'h123456789ABCDEF, 1'b0, '0);
        check("wm0_csb0", csb0, 1'b1);
        check("wm0_web0", web0, 1'b1);
`ifdef SRAM_CTRL_STATS_EN
        check("wm0_wr_cnt", wr_cnt, 16'd3);
`endif
        do_req(1'b0, 6'd5, 4'b0000, '0, 1'b1, 88'hFFFFFC00000);
        wait_idle();

        // Fill every word with a known pattern.
        for (int a = 0; a < 64; a++) do_req(1'b1, AW'(a), 4'b1111, pat(a), 1'b0, '0);
        wait_idle();

        // Credit limit: eight reads offered with the consumer stalled.
        rsp_ready = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            if (req_ready) begin
                acc++;
                exp_q.push_back(pat(i));
            end
            @(posedge clk0); #1;
        end
        req_valid = 1'b0;
        check("credit_accepts", acc, 4);
        check("credit_ready_low", req_ready, 1'b0);
        repeat (3) @(posedge clk0);
        #1;
        check("credit_rsp_valid", rsp_valid, 1'b1);
        check("credit_ready_still_low", req_ready, 1'b0);
        rsp_ready = 1'b1;
        @(posedge clk0); #1;
        check("ready_after_first_pop", req_ready, 1'b1);
        wait_idle();

        // Reset one cycle after a read acceptance discards that read.
        do_req(1'b0, 6'd3, 4'b0000, '0, 1'b0, '0);
        rst0 = 1'b1;
        @(posedge clk0); #1;
        check("rstrd_csb0_in_rst", csb0, 1'b1);
        rst0 = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk0);
            if (rsp_valid) seen = 1'b1;
        end
        check("rstrd_no_rsp", seen, 1'b0);
        check("rstrd_csb0", csb0, 1'b1);
        check("rstrd_fifo_empty", rsp_valid, 1'b0);
        check("rstrd_ready", req_ready, 1'b1);

        // 64 back-to-back reads with the consumer always ready.
        @(posedge clk0); #1;
        acc = 0;
        for (int i = 0; i < 64; i++) begin
            req_valid = 1'b1;
            req_we    = 1'b0;
            req_addr  = AW'(i);
            if (req_ready) begin
                acc++;
                exp_q.push_back(pat(i));
            end
            @(posedge clk0); #1;
        end
        req_valid = 1'b0;
        check("stream_accepts", acc, 64);
        wait_idle();
`ifdef SRAM_CTRL_STATS_EN
        check("stream_rd_cnt", rd_cnt, 16'd64);
        check("stream_wr_cnt", wr_cnt, 16'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
